// File: rtl/ysyx_24080006_ifu_queue.sv
// Instruction fetch unit with an in-order prefetch queue feeding the decoder.
// Issues sequential word fetches, keeps returned words with their PC, and
// drops words that are still in flight when a redirect (flush) arrives.
//
// Handshakes: every valid/ready pair transfers exactly when valid & ready are
// both high in the same cycle. On the fetch bus, mem_req_valid_o may fall
// before it is accepted. Decode pops the head on out_valid_o & out_ready_i.
module ysyx_24080006_ifu_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_resp_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  output logic        out_fault_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic          halted;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [31:0] q_inst  [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic        q_fault [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          resp_live;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   flush_target;
  logic          unused_flush_bits;

  // Low address bits of the redirect target are forced to a word boundary.
  assign flush_target      = {flush_pc_i[31:2], 2'b00};
  assign unused_flush_bits = ^flush_pc_i[1:0];

  // Credit rule: every in-flight word already owns a queue slot.
  assign occupancy       = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid_o = ~reset & ~flush_i & ~halted & (occupancy < (CW+1)'(DEPTH));
  assign mem_req_addr_o  = fetch_pc;
  assign req_fire        = mem_req_valid_o & mem_req_ready_i;

  // A response with nothing outstanding (e.g. from before a reset) is ignored.
  assign resp_live = ~reset & mem_resp_valid_i & (outstanding != '0);
  assign push      = resp_live & (discard == '0) & ~flush_i;

  assign out_valid_o = ~reset & (count != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_inst_o  = out_valid_o ? q_inst[rd_ptr] : 32'h0;
  assign out_pc_o    = out_valid_o ? q_pc[rd_ptr]   : 32'h0;
  assign out_fault_o = out_valid_o & q_fault[rd_ptr];

  assign outstanding_nxt = outstanding - CW'(resp_live) + CW'(req_fire);

  // Control state: counters, PCs, discard budget and halt flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush_i) begin
        // Everything still in flight after this cycle becomes stale.
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= flush_target;
        resp_pc  <= flush_target;
        halted   <= 1'b0;
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_live && discard != '0) discard <= discard - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
          if (mem_resp_err_i) halted <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue payload storage; faulted words are stored with a zero instruction.
  always_ff @(posedge clock) begin
    if (push) begin
      q_inst[wr_ptr]  <= mem_resp_err_i ? 32'h0 : mem_resp_data_i;
      q_pc[wr_ptr]    <= resp_pc;
      q_fault[wr_ptr] <= mem_resp_err_i;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_ifu_queue.sv
// Directed bench for the fetch queue: a cycle table for streaming and
// backpressure, plus hand sequences for flush, fault and reset corner cases.
module tb_ysyx_24080006_ifu_queue;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] fpc;
    logic        req_rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        ordy;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_fault;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
  logic        mem_resp_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_fault_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int step   = 0;

  ysyx_24080006_ifu_queue dut (
    .clock            (clock),
    .reset            (reset),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_err_i   (mem_resp_err_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_inst_o       (out_inst_o),
    .out_pc_o         (out_pc_o),
    .out_fault_o      (out_fault_o)
  );

  // Clock and initial input levels
  initial begin
    clock            = 1'b0;
    reset            = 1'b1;
    flush_i          = 1'b0;
    flush_pc_i       = 32'h0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = 32'h0;
    mem_resp_err_i   = 1'b0;
    out_ready_i      = 1'b0;
  end
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic fl, input logic [31:0] fpc,
                              input logic rr, input logic rv, input logic [31:0] rd,
                              input logic re, input logic orr, input logic erv,
                              input logic [31:0] ea, input logic eov, input logic [31:0] epc,
                              input logic [31:0] einst, input logic ef);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fpc = fpc; v.req_rdy = rr; v.rv = rv; v.rd = rd;
    v.re = re; v.ordy = orr; v.e_req_v = erv; v.e_addr = ea; v.e_ov = eov;
    v.e_pc = epc; v.e_inst = einst; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h expected %h", step, nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, check just after, then let the rising edge happen.
  task automatic cyc(input vec_t v);
    @(negedge clock);
    reset            = v.rst;
    flush_i          = v.fl;
    flush_pc_i       = v.fpc;
    mem_req_ready_i  = v.req_rdy;
    mem_resp_valid_i = v.rv;
    mem_resp_data_i  = v.rd;
    mem_resp_err_i   = v.re;
    out_ready_i      = v.ordy;
    #1;
    chk("req_valid", {31'h0, mem_req_valid_o}, {31'h0, v.e_req_v});
    if (v.e_req_v) chk("req_addr", mem_req_addr_o, v.e_addr);
    chk("out_valid", {31'h0, out_valid_o}, {31'h0, v.e_ov});
    chk("out_pc", out_pc_o, v.e_pc);
    chk("out_inst", out_inst_o, v.e_inst);
    chk("out_fault", {31'h0, out_fault_o}, {31'h0, v.e_fault});
    step++;
  endtask

  // Stimulus, scoreboard comparisons and final report
  initial begin
    vec_t tbl[$];

    // Streaming with 1-cycle responses (first word visible 2 cycles after first accept)
    tbl.push_back(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0000, 0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h1111_1111,0,1, 1,32'h3000_0004, 0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h2222_2222,0,1, 0,32'h0, 1,32'h3000_0000,32'h1111_1111,0));
    tbl.push_back(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0008, 1,32'h3000_0004,32'h2222_2222,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h3333_3333,0,1, 1,32'h3000_000c, 0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h4444_4444,0,1, 0,32'h0, 1,32'h3000_0008,32'h3333_3333,0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0010, 1,32'h3000_000c,32'h4444_4444,0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,0,0, 1,32'h3000_0010, 0,32'h0,32'h0,0));
    // Decode stalled for 10 cycles: queue fills, requests stop, then drains in order
    tbl.push_back(mk(0,0,0, 1,0,32'h0,0,0, 1,32'h3000_0010, 0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h5555_5555,0,0, 1,32'h3000_0014, 0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h6666_6666,0,0, 0,32'h0, 1,32'h3000_0010,32'h5555_5555,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0,0,0, 1,0,32'h0,0,0, 0,32'h0, 1,32'h3000_0010,32'h5555_5555,0));
    tbl.push_back(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 1,32'h3000_0010,32'h5555_5555,0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0018, 1,32'h3000_0014,32'h6666_6666,0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,0,0, 1,32'h3000_0018, 0,32'h0,32'h0,0));

    // Reset: all outputs quiet
    cyc(mk(1,0,0, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(1,0,0, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));

    foreach (tbl[i]) cyc(tbl[i]);

    // Flush with two requests in flight: both stale words dropped, restart word aligned
    cyc(mk(0,0,0, 1,0,32'h0,0,0, 1,32'h3000_0018, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,0, 1,32'h3000_001c, 0,32'h0,32'h0,0));
    cyc(mk(0,1,32'h8000_0102, 1,0,32'h0,0,0, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'hbad0_0001,0,0, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'hbad0_0002,0,0, 1,32'h8000_0100, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,1,32'h7777_7777,0,0, 1,32'h8000_0104, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h8000_0104, 1,32'h8000_0100,32'h7777_7777,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,0, 1,32'h8000_0104, 0,32'h0,32'h0,0));

    // Flush coincident with a response and a decode handshake
    cyc(mk(0,0,0, 1,0,32'h0,0,0, 1,32'h8000_0104, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'h8888_8888,0,0, 1,32'h8000_0108, 0,32'h0,32'h0,0));
    cyc(mk(0,1,32'h3000_0040, 1,1,32'h9999_9998,0,1, 0,32'h0, 1,32'h8000_0104,32'h8888_8888,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0040, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,1,32'heeee_eeee,0,1, 1,32'h3000_0040, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0040, 0,32'h0,32'h0,0));

    // Bus error on 0x30000008: faulted head, fetch halted until the next flush
    cyc(mk(0,1,32'h3000_0000, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0000, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'h9999_9999,0,1, 1,32'h3000_0004, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'haaaa_aaaa,0,1, 0,32'h0, 1,32'h3000_0000,32'h9999_9999,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0008, 1,32'h3000_0004,32'haaaa_aaaa,0));
    cyc(mk(0,0,0, 1,1,32'hdead_beef,1,1, 1,32'h3000_000c, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'hbbbb_bbbb,0,0, 0,32'h0, 1,32'h3000_0008,32'h0,1));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 1,32'h3000_0008,32'h0,1));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 1,32'h3000_000c,32'hbbbb_bbbb,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,1,32'h3000_0100, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0100, 0,32'h0,32'h0,0));

    // Reset with two words outstanding; their late responses are ignored
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0100, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0104, 0,32'h0,32'h0,0));
    cyc(mk(1,0,0, 1,0,32'h0,0,1, 0,32'h0, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,1,32'hcccc_cccc,0,1, 1,32'h3000_0000, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,1,32'hdddd_dddd,0,1, 1,32'h3000_0000, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 1,32'h3000_0000, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,1,32'h1234_5678,0,1, 1,32'h3000_0004, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 1,0,32'h0,0,1, 0,32'h0, 1,32'h3000_0000,32'h1234_5678,0));
    cyc(mk(0,0,0, 0,1,32'h9abc_def0,0,1, 1,32'h3000_0008, 0,32'h0,32'h0,0));
    cyc(mk(0,0,0, 0,0,32'h0,0,1, 1,32'h3000_0008, 1,32'h3000_0004,32'h9abc_def0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
